// File: rtl/cam_frame_gen.sv
// cam_frame_gen: OV-style VSYNC/HREF/DATA camera stimulus generator with test patterns.
// Define CAM_FRAME_GEN_CRC_EN to add a per-frame CRC-8 of the active bytes on crc.
module cam_frame_gen #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int BPP         = 2,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 4,
  parameter int V_FRONT     = 4
) (
  input  logic        PCLK,
  input  logic        RESET,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [7:0]  pat_value,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  DATA,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
`ifdef CAM_FRAME_GEN_CRC_EN
  ,
  output logic [7:0]  crc
`endif
);

  // state  | meaning
  // IDLE   | stopped, waiting for enable
  // SYNC   | VSYNC high for VSYNC_LINES line periods
  // VBACK  | blank lines after VSYNC
  // ACTIVE | V_ACTIVE lines of HREF/DATA followed by H_BLANK
  // VFRONT | blank lines after the last active line
  // END    | one-cycle frame_done, busy low
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_VBACK, S_ACTIVE, S_VFRONT, S_END} state_t;

  localparam int AB   = H_ACTIVE * BPP;
  localparam int L    = AB + H_BLANK;
  localparam int HW   = $clog2(L + 1);
  localparam int VM1  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VM2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
  localparam int LW   = $clog2(VMAX + 1);
  localparam int XW   = ($clog2(H_ACTIVE + 1) < 4) ? 4 : $clog2(H_ACTIVE + 1);
  localparam int YW   = ($clog2(V_ACTIVE + 1) < 4) ? 4 : $clog2(V_ACTIVE + 1);
  localparam int PW   = $clog2(BPP + 1);

  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] AB_W   = HW'(AB);
  localparam logic [PW-1:0] P_LAST = PW'(BPP - 1);

  state_t         state, state_nx;
  logic [HW-1:0]  h, h_nx;
  logic [LW-1:0]  ln, ln_nx;
  logic [YW-1:0]  y, y_nx;
  logic [XW-1:0]  x, x_nx;
  logic [PW-1:0]  px, px_nx;
  logic [1:0]     mode_q, mode_nx;
  logic [7:0]     pat_q, pat_nx, fid_q, fid_nx;
  logic           start, line_end, phase_end;
  logic           href_nx, done_nx, busy_nx;
  logic [7:0]     data_nx;

  always_comb begin
    state_nx  = state;
    h_nx      = h;
    ln_nx     = ln;
    y_nx      = y;
    x_nx      = x;
    px_nx     = px;
    start     = 1'b0;
    line_end  = (h == H_LAST);
    phase_end = line_end && (ln == '0);

    if (state inside {S_SYNC, S_VBACK, S_ACTIVE, S_VFRONT}) begin
      h_nx = line_end ? '0 : h + 1'b1;
      if (line_end) ln_nx = ln - 1'b1;
      if (line_end || px == P_LAST) px_nx = '0;
      else px_nx = px + 1'b1;
      if (line_end) x_nx = '0;
      else if (px == P_LAST) x_nx = x + 1'b1;
      if (line_end && state == S_ACTIVE) y_nx = y + 1'b1;
    end

    case (state)
      S_IDLE: start = enable;
      S_SYNC:
        if (phase_end) begin
          if (V_BACK > 0) begin
            state_nx = S_VBACK;
            ln_nx    = LW'(V_BACK - 1);
          end else begin
            state_nx = S_ACTIVE;
            ln_nx    = LW'(V_ACTIVE - 1);
          end
        end
      S_VBACK:
        if (phase_end) begin
          state_nx = S_ACTIVE;
          ln_nx    = LW'(V_ACTIVE - 1);
        end
      S_ACTIVE:
        if (phase_end) begin
          if (V_FRONT > 0) begin
            state_nx = S_VFRONT;
            ln_nx    = LW'(V_FRONT - 1);
          end else begin
            state_nx = S_END;
          end
        end
      S_VFRONT: if (phase_end) state_nx = S_END;
      S_END: begin
        start = enable;
        if (!enable) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (start) begin
      state_nx = S_SYNC;
      h_nx     = '0;
      ln_nx    = LW'(VSYNC_LINES - 1);
      y_nx     = '0;
      x_nx     = '0;
      px_nx    = '0;
    end

    // Outputs are computed for the upcoming cycle so every port comes straight from a flop.
    mode_nx = start ? mode : mode_q;
    pat_nx  = start ? pat_value : pat_q;
    fid_nx  = start ? frame_cnt[7:0] : fid_q;
    done_nx = (state_nx == S_END);
    busy_nx = state_nx inside {S_SYNC, S_VBACK, S_ACTIVE, S_VFRONT};
    href_nx = (state_nx == S_ACTIVE) && (h_nx < AB_W);
    data_nx = '0;
    if (href_nx) begin
      case (mode_nx)
        2'd0:    data_nx = 8'(h_nx) + 8'(y_nx);
        2'd1:    data_nx = (x_nx[3] ^ y_nx[3]) ? 8'hFF : 8'h00;
        2'd2:    data_nx = fid_nx;
        default: data_nx = pat_nx;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      h          <= '0;
      ln         <= '0;
      y          <= '0;
      x          <= '0;
      px         <= '0;
      mode_q     <= '0;
      pat_q      <= '0;
      fid_q      <= '0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      DATA       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      h          <= h_nx;
      ln         <= ln_nx;
      y          <= y_nx;
      x          <= x_nx;
      px         <= px_nx;
      mode_q     <= mode_nx;
      pat_q      <= pat_nx;
      fid_q      <= fid_nx;
      VSYNC      <= (state_nx == S_SYNC);
      HREF       <= href_nx;
      DATA       <= data_nx;
      frame_done <= done_nx;
      busy       <= busy_nx;
      if (done_nx) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef CAM_FRAME_GEN_CRC_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  logic [7:0] crc_acc;

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      crc_acc <= '0;
      crc     <= '0;
    end else begin
      if (start) crc_acc <= '0;
      else if (href_nx) crc_acc <= crc8_byte(crc_acc, data_nx);
      if (done_nx) crc <= crc_acc;
    end
  end
`endif

endmodule

// File: tb/tb_cam_frame_gen.sv
// Self-checking bench for cam_frame_gen: spot-value table, directed frame sequences and
// randomized frames compared against a frame-geometry reference model.
module tb_cam_frame_gen;

  localparam int H_ACTIVE    = 84;
  localparam int V_ACTIVE    = 12;
  localparam int BPP         = 3;
  localparam int H_BLANK     = 8;
  localparam int VSYNC_LINES = 2;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 0;
  localparam int AB = H_ACTIVE * BPP;
  localparam int L  = AB + H_BLANK;
  localparam int F  = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * L;

  logic        PCLK = 1'b0;
  logic        RESET;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  pat_value;
  logic        VSYNC, HREF, frame_done, busy;
  logic [7:0]  DATA;
  logic [15:0] frame_cnt;
`ifdef CAM_FRAME_GEN_CRC_EN
  logic [7:0]  crc;
`endif

  cam_frame_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BPP(BPP), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .PCLK(PCLK), .RESET(RESET), .enable(enable), .mode(mode), .pat_value(pat_value),
    .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
`ifdef CAM_FRAME_GEN_CRC_EN
    , .crc(crc)
`endif
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [15:0] exp_cnt;
  logic [7:0]  exp_crc_prev;
  logic [7:0]  cap [2][V_ACTIVE][AB];
  int          done_cyc [$];

  typedef struct {
    int         sel;
    int         y;
    int         b;
    logic [7:0] exp;
  } spot_t;
  spot_t spots [16];

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(int m, int pv, int fid, int yy, int b);
    case (m)
      0:       return 8'((b + yy) % 256);
      1:       return ((((b / BPP) / 8) % 2) != ((yy / 8) % 2)) ? 8'hFF : 8'h00;
      2:       return 8'(fid);
      default: return 8'(pv);
    endcase
  endfunction

  function automatic logic [7:0] crc8_model(logic [7:0] c, logic [7:0] d);
    logic [7:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      logic fb = r[7] ^ d[i];
      r = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  int gap_last_two;
  task automatic last_gap();
    int n = done_cyc.size();
    gap_last_two = (n >= 2) ? done_cyc[n-1] - done_cyc[n-2] : -1;
  endtask

  // Walks one frame from its first cycle (k=0) to stop_k, comparing every cycle with the model.
  task automatic check_frame(input int m, input int pv, input int cap_sel,
                             input int chg_k, input int new_m, input int new_pv, input bit chg_en,
                             input int en_k, input bit new_en, input int stop_k);
    int err = 0, vs_hi = 0, pulses = 0, bad_len = 0, bad_gap = 0, run = 0, last_rise = -1;
    int fid;
    logic [7:0] crc_run = 8'h00;
    fid = int'(exp_cnt[7:0]);
    for (int k = 0; k <= stop_k; k++) begin
      logic e_vs, e_href, e_done, e_busy;
      logic [7:0] e_data;
      logic [15:0] e_cnt;
      int line, col, ya;
      @(negedge PCLK);
      line = k / L;
      col  = k % L;
      ya   = line - VSYNC_LINES - V_BACK;
      if (k < F) begin
        e_vs   = (line < VSYNC_LINES);
        e_href = (ya >= 0) && (ya < V_ACTIVE) && (col < AB);
        e_data = e_href ? exp_byte(m, pv, fid, ya, col) : 8'h00;
        e_done = 1'b0;
        e_busy = 1'b1;
        e_cnt  = exp_cnt;
        if (e_href) crc_run = crc8_model(crc_run, e_data);
      end else begin
        e_vs = 1'b0; e_href = 1'b0; e_data = 8'h00; e_done = 1'b1; e_busy = 1'b0;
        e_cnt = exp_cnt + 16'd1;
      end
      if ({VSYNC, HREF, DATA, frame_done, busy, frame_cnt} !==
          {e_vs, e_href, e_data, e_done, e_busy, e_cnt}) begin
        if (err == 0)
          $display("  first stream difference k=%0d vs/href/data/done/busy/cnt got %b %b %h %b %b %0d want %b %b %h %b %b %0d",
                   k, VSYNC, HREF, DATA, frame_done, busy, frame_cnt,
                   e_vs, e_href, e_data, e_done, e_busy, e_cnt);
        err++;
      end
`ifdef CAM_FRAME_GEN_CRC_EN
      if (crc !== ((k < F) ? exp_crc_prev : crc_run)) begin
        if (err == 0) $display("  first crc difference k=%0d got %h", k, crc);
        err++;
      end
`endif
      if (VSYNC === 1'b1) vs_hi++;
      if (HREF === 1'b1) begin
        if (run == 0) begin
          if (last_rise >= 0 && k - last_rise != L) bad_gap++;
          last_rise = k;
          pulses++;
        end
        if (cap_sel >= 0 && pulses <= V_ACTIVE && run < AB) cap[cap_sel][pulses-1][run] = DATA;
        run++;
      end else begin
        if (run != 0 && run != AB) bad_len++;
        run = 0;
      end
      if (k == F && frame_done === 1'b1) done_cyc.push_back(cyc);
      if (k == chg_k) begin
        mode      = 2'(new_m);
        pat_value = 8'(new_pv);
        enable    = chg_en;
      end
      if (k == en_k) enable = new_en;
    end
    if (stop_k >= F) begin
      exp_cnt      = exp_cnt + 16'd1;
      exp_crc_prev = crc_run;
      check("vsync high cycles", vs_hi, VSYNC_LINES * L);
      check("href pulse count", pulses, V_ACTIVE);
      check("href length/spacing errors", bad_len + bad_gap, 0);
    end
    check("frame stream", err, 0);
  endtask

  task automatic check_idle(input string name);
    @(negedge PCLK);
    check(name, {busy, VSYNC, HREF, DATA, frame_done}, 0);
  endtask

  initial begin
    int cm, cp, nm, npv, chg, enk, keep, nd;
    bit running;

    spots[0]  = '{0, 3, 0, 8'h03};
    spots[1]  = '{0, 3, 1, 8'h04};
    spots[2]  = '{0, 3, 251, 8'hFE};
    spots[3]  = '{0, 4, 251, 8'hFF};
    spots[4]  = '{0, 5, 251, 8'h00};
    spots[5]  = '{0, 11, 251, 8'h06};
    spots[6]  = '{0, 0, 200, 8'hC8};
    spots[7]  = '{1, 0, 0, 8'h00};
    spots[8]  = '{1, 0, 23, 8'h00};
    spots[9]  = '{1, 0, 24, 8'hFF};
    spots[10] = '{1, 0, 47, 8'hFF};
    spots[11] = '{1, 0, 48, 8'h00};
    spots[12] = '{1, 8, 0, 8'hFF};
    spots[13] = '{1, 8, 24, 8'h00};
    spots[14] = '{1, 11, 251, 8'hFF};
    spots[15] = '{1, 7, 72, 8'hFF};

    RESET = 1'b1; enable = 1'b0; mode = 2'd0; pat_value = 8'h00;
    exp_cnt = 16'd0; exp_crc_prev = 8'h00;
    repeat (3) @(negedge PCLK);
    check("reset VSYNC", VSYNC, 0);
    check("reset HREF", HREF, 0);
    check("reset DATA", DATA, 0);
    check("reset frame_done", frame_done, 0);
    check("reset frame_cnt", frame_cnt, 0);
    check("reset busy", busy, 0);
`ifdef CAM_FRAME_GEN_CRC_EN
    check("reset crc", crc, 0);
`endif
    RESET = 1'b0;
    repeat (4) check_idle("idle with enable low");

    // Frame A: ramp, enable dropped early; frame must still complete.
    mode = 2'd0; enable = 1'b1;
    check_frame(0, 0, 0, -1, 0, 0, 1'b0, 10, 1'b0, F);
    check_idle("idle after ramp frame");
    check("frame_cnt after first frame", frame_cnt, 1);

    // Frame B: checker.
    mode = 2'd1; enable = 1'b1;
    check_frame(1, 0, 1, -1, 0, 0, 1'b0, 10, 1'b0, F);
    check_idle("idle after checker frame");

    for (int i = 0; i < 16; i++)
      check($sformatf("spot sel%0d y%0d b%0d", spots[i].sel, spots[i].y, spots[i].b),
            cap[spots[i].sel][spots[i].y][spots[i].b], spots[i].exp);

    // Constant pattern changed mid-frame takes effect only on the next frame.
    mode = 2'd3; pat_value = 8'hA5; enable = 1'b1;
    check_frame(3, 'hA5, -1, F / 2, 3, 'h3C, 1'b1, -1, 1'b0, F);
    check_frame(3, 'h3C, -1, -1, 0, 0, 1'b0, 10, 1'b0, F);
    last_gap();
    check("back-to-back frame_done gap", gap_last_two, F + 1);
    check_idle("idle after constant frames");

    // Frame id after reset, three back-to-back frames, reset aborts the third.
    RESET = 1'b1;
    @(negedge PCLK);
    RESET = 1'b0;
    exp_cnt = 16'd0; exp_crc_prev = 8'h00;
    check("frame_cnt after reset", frame_cnt, 0);
    mode = 2'd2; enable = 1'b1;
    check_frame(2, 0, -1, -1, 0, 0, 1'b0, -1, 1'b0, F);
    check_frame(2, 0, -1, -1, 0, 0, 1'b0, -1, 1'b0, F);
    last_gap();
    check("frame id frame_done gap", gap_last_two, F + 1);
    check_frame(2, 0, -1, -1, 0, 0, 1'b0, -1, 1'b0, F / 2);
    enable = 1'b0;
    RESET = 1'b1;
    #1;
    check("mid-frame reset outputs", {VSYNC, HREF, DATA, frame_done, busy}, 0);
    check("mid-frame reset frame_cnt", frame_cnt, 0);
    @(negedge PCLK);
    RESET = 1'b0;
    exp_cnt = 16'd0; exp_crc_prev = 8'h00;
    nd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (frame_done === 1'b1 || busy === 1'b1) nd++;
    end
    check("no frame_done/busy after abort", nd, 0);

    // Randomized frames: pattern, mid-frame input noise and stop/continue decisions.
    running = 1'b0; cm = 0; cp = 0;
    for (int f = 0; f < 4; f++) begin
      if (!running) begin
        repeat ($urandom_range(1, 5)) check_idle("idle between random frames");
        cm = $urandom_range(0, 3);
        cp = $urandom_range(0, 255);
        mode = 2'(cm); pat_value = 8'(cp); enable = 1'b1;
      end
      nm   = $urandom_range(0, 3);
      npv  = $urandom_range(0, 255);
      chg  = $urandom_range(0, F / 2);
      enk  = $urandom_range(F / 2 + 1, F - 1);
      keep = (f == 3) ? 0 : $urandom_range(0, 1);
      check_frame(cm, cp, -1, chg, nm, npv, $urandom_range(0, 1) != 0, enk, keep != 0, F);
      cm = nm; cp = npv; running = (keep != 0);
    end
    check_idle("idle at end");
    check("final frame_cnt", frame_cnt, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_frame_gen.md
Name: cam_frame_gen

Overview:
Parametrised, synthesizable camera-sensor stimulus generator. Produces OV-style VSYNC/HREF/DATA streams with configurable geometry, blanking and bytes per pixel, plus selectable test patterns and frame counting. Feeds the camera capture path in place of the sensor on FPGA bring-up builds and in the test_top bench, with per-frame start/stop control.

Parameters:
H_ACTIVE, 160, active pixels per line
V_ACTIVE, 120, active lines per frame
BPP, 2, bytes per pixel (1..4); active bytes per line AB = H_ACTIVE*BPP
H_BLANK, 16, HREF-low cycles after each line
VSYNC_LINES, 2, line periods VSYNC is high
V_BACK, 4, blank line periods after VSYNC
V_FRONT, 4, blank line periods after last active line

Ports:
PCLK  in  1  pixel clock; one DATA byte per cycle
RESET  in  1  asynchronous, active-high reset
enable  in  1  run request, sampled only at frame boundaries
mode  in  2  pattern select, latched at frame start
pat_value  in  8  constant byte for mode 3, latched at frame start
VSYNC  out  1  frame sync, active high
HREF  out  1  line valid, active high
DATA  out  8  pixel byte; 0 when HREF low
frame_done  out  1  one-cycle pulse at end of each frame
frame_cnt  out  16  completed-frame count
busy  out  1  high from frame start until frame_done

Behaviour:
- Line period L = AB + H_BLANK PCLK cycles; frame = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT)*L cycles, +1 IDLE cycle when stopped.
- Reset: all outputs 0, state IDLE, counters 0, latched mode/pat_value 0. Asserting RESET mid-frame aborts immediately; no frame_done.
- All outputs registered; first VSYNC high cycle is the cycle after enable is seen high in IDLE.
- States: IDLE -> SYNC (VSYNC=1, VSYNC_LINES*L cycles) -> VBACK (V_BACK*L) -> ACTIVE (V_ACTIVE lines: HREF=1 for AB cycles, then HREF=0 for H_BLANK) -> VFRONT (V_FRONT*L) -> END.
- END (1 cycle): frame_done=1, frame_cnt+1 (wraps 0xFFFF->0). If enable=1, next cycle enters SYNC (back-to-back frames, busy stays 1 except low during END); else IDLE, busy=0.
- enable deasserted mid-frame: current frame completes normally.
- Zero-length phases (V_BACK=0, V_FRONT=0) are skipped; VSYNC_LINES, V_ACTIVE, H_ACTIVE >= 1.
- Indices: b = byte index in line 0..AB-1; x = b/BPP (BPP counter, no divider); y = active line 0..V_ACTIVE-1.
- Patterns (HREF high only):
  - mode 0 ramp: DATA = (b + y) mod 256
  - mode 1 checker: DATA = (x[3] ^ y[3]) ? 8'hFF : 8'h00
  - mode 2 frame id: DATA = frame_cnt[7:0] value at frame start
  - mode 3 constant: DATA = latched pat_value
- mode/pat_value changes mid-frame have no effect until next frame.

Optional Feature:
Macro CAM_FRAME_GEN_CRC_EN. Defined: extra output crc 8 bits; CRC-8 (poly 0x07, init 0x00, MSB first) over every active DATA byte of the frame, valid and stable from END cycle until next END; reset 0. Undefined: no crc port, no CRC logic.

Test Plan:
- Defaults, mode 0, enable held 1 for one frame then 0 -> VSYNC high 672 cycles, 120 HREF pulses of 320 cycles spaced 336, frame_done after 43680 cycles, frame_cnt=1, busy=0.
- Mode 0 -> line y=3 bytes 3,4,...,255,0,...; line 200-byte-wrap verified; DATA=0 during all HREF-low cycles.
- Mode 1, BPP=2 -> line 0 bytes 0..15 = 0x00, 16..31 = 0xFF; line 8 inverted.
- Mode 3 pat_value=0xA5, switch to 0x3C mid-frame -> whole frame 0xA5, next frame 0x3C.
- enable held 1, 3 frames -> frame_done pulses 43681 cycles apart, mode 2 DATA 0x00/0x01/0x02; RESET at mid-frame 2 -> all outputs 0 next cycle, frame_cnt=0.
- CAM_FRAME_GEN_CRC_EN, mode 3 pat_value=0x00 -> crc=0x00; mode 0 frame -> crc matches bench CRC-8 model.
